// File: rtl/cr_prefix_rec_arb.sv
// -----------------------------------------------------------------------------
// cr_prefix_rec_arb
// Shares one single-port record memory between a core read port and a
// register-side indirect read. The core normally owns the memory slot. A
// pending register read takes the slot when the core is idle, or when the core
// has already been granted MAX_CORE_RUN times while the register read waited.
// A core request that loses its slot is dropped and flagged with core_yield.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   core_req/core_addr    single-cycle core read request
//   core_gnt              combinational grant of core_req this cycle
//   core_yield            core request dropped in favour of a register read
//   core_rvalid/rdata     core read data, one cycle after core_gnt
//   reg_req/reg_addr      4-phase register read request (level)
//   reg_ack               register read complete, held until reg_req falls
//   reg_rdata/reg_err     captured register read data and uncorrectable ECC flag
//   mem_cs/mem_addr       record-memory read strobe and address
//   mem_rdata/mem_ecc_err memory read data and ECC flag, one cycle after mem_cs
//
// Register FSM
//   state | meaning
//   IDLE  | no register read in progress
//   PEND  | register read waiting for the memory slot
//   RD    | register read issued last cycle, memory data arriving now
//   CAP   | data captured, reg_ack presented
//   ACK   | waiting for reg_req to fall
// -----------------------------------------------------------------------------
module cr_prefix_rec_arb #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 64,
  parameter int MAX_CORE_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_gnt,
  output logic              core_yield,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              reg_req,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic              reg_ack,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_err,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ecc_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PEND = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    ACK  = 3'd4
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(MAX_CORE_RUN);

  state_t     state, state_nxt;
  logic [3:0] run_ctr, run_ctr_nxt;
  logic       ready;
  logic       reg_gnt;
  logic       reg_ack_nxt;

  always_comb begin
    state_nxt   = state;
    run_ctr_nxt = run_ctr;
    reg_gnt     = 1'b0;
    reg_ack_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (ready && reg_req) state_nxt = PEND;
      end
      PEND: begin
        if (!reg_req) begin
          // withdrawn before the slot was won: no memory access
          state_nxt   = IDLE;
          run_ctr_nxt = '0;
        end else if (!core_req || run_ctr == RUN_MAX) begin
          reg_gnt     = 1'b1;
          state_nxt   = RD;
          run_ctr_nxt = '0;
        end else begin
          // core keeps the slot; cannot pass RUN_MAX since that case grants
          run_ctr_nxt = run_ctr + 4'd1;
        end
      end
      RD: begin
        state_nxt   = CAP;
        reg_ack_nxt = 1'b1;
      end
      CAP: begin
        // a requester that already dropped sees exactly one ack cycle
        state_nxt   = ACK;
        reg_ack_nxt = reg_req;
      end
      ACK: begin
        reg_ack_nxt = reg_req;
        if (!reg_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ready is low during reset and for the first edge after it, which keeps
  // both requesters out until the block has seen one clean clock edge.
  assign core_gnt   = ready & core_req & ~reg_gnt;
  assign core_yield = reg_gnt & core_req;
  assign mem_cs     = core_gnt | reg_gnt;
  assign mem_addr   = reg_gnt ? reg_addr : core_addr;
  assign core_rdata = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      run_ctr     <= '0;
      ready       <= 1'b0;
      core_rvalid <= 1'b0;
      reg_ack     <= 1'b0;
      reg_rdata   <= '0;
      reg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      run_ctr     <= run_ctr_nxt;
      ready       <= 1'b1;
      core_rvalid <= core_gnt;
      reg_ack     <= reg_ack_nxt;
      if (state == RD) begin
        reg_rdata <= mem_rdata;
        reg_err   <= mem_ecc_err;
      end
    end
  end

endmodule

// File: tb/tb_cr_prefix_rec_arb.sv
// -----------------------------------------------------------------------------
// tb_cr_prefix_rec_arb
// Directed scenarios followed by randomized traffic. A behavioural memory
// answers reads; a transaction-level model (pending request, run count, age of
// the in-flight register read) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_cr_prefix_rec_arb;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int MAXR   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              core_req = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic              core_gnt, core_yield, core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              reg_req = 1'b0;
  logic [ADDR_W-1:0] reg_addr = '0;
  logic              reg_ack, reg_err;
  logic [DATA_W-1:0] reg_rdata;
  logic              mem_cs;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ecc_err = 1'b0;

  logic [DATA_W-1:0] mem [1024];
  logic              ecc [1024];

  int total = 0;
  int bad   = 0;

  // reference model state
  bit                m_ready, m_pend, m_busy, m_ack, m_prev_gnt;
  int                m_runs, m_age;
  logic [ADDR_W-1:0] m_gaddr, m_prev_caddr;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;

  // DUT snapshot of the last sampled cycle
  logic              s_gnt, s_yield, s_cs, s_rvalid, s_ack, s_err;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_rdata;

  // random requester state
  bit                rq;
  logic [ADDR_W-1:0] rq_addr;
  int                low_cnt;

  cr_prefix_rec_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CORE_RUN(MAXR)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
    .core_yield(core_yield), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .reg_req(reg_req), .reg_addr(reg_addr), .reg_ack(reg_ack),
    .reg_rdata(reg_rdata), .reg_err(reg_err),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ecc_err(mem_ecc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs === 1'b1) begin
      mem_rdata   <= mem[mem_addr];
      mem_ecc_err <= ecc[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_pend = 0; m_busy = 0; m_ack = 0; m_prev_gnt = 0;
    m_runs = 0; m_age = 0; m_gaddr = '0; m_prev_caddr = '0;
    m_rdata = '0; m_err = 1'b0;
  endtask

  // Enter at posedge+1 with the previous cycle done; leave at posedge+1.
  task automatic do_reset(input logic cr);
    core_req = cr;
    rst = 1'b1;
    #1;
    chk("rst_core_gnt",    64'(core_gnt),    64'd0);
    chk("rst_core_yield",  64'(core_yield),  64'd0);
    chk("rst_mem_cs",      64'(mem_cs),      64'd0);
    chk("rst_core_rvalid", 64'(core_rvalid), 64'd0);
    chk("rst_reg_ack",     64'(reg_ack),     64'd0);
    chk("rst_reg_rdata",   64'(reg_rdata),   64'd0);
    chk("rst_reg_err",     64'(reg_err),     64'd0);
    @(posedge clk);
    #1;
    chk("rst_held_core_gnt", 64'(core_gnt), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic cr, input logic [ADDR_W-1:0] ca,
                      input logic rr, input logic [ADDR_W-1:0] ra);
    bit rg, eg, ey, ecs, new_ack;
    logic [ADDR_W-1:0] ea;
    core_req = cr; core_addr = ca; reg_req = rr; reg_addr = ra;
    @(negedge clk);
    rg  = m_ready && m_pend && rr && (!cr || m_runs == MAXR);
    eg  = m_ready && cr && !rg;
    ey  = rg && cr;
    ecs = eg || rg;
    ea  = rg ? ra : ca;
    s_gnt = core_gnt; s_yield = core_yield; s_cs = mem_cs; s_addr = mem_addr;
    s_rvalid = core_rvalid; s_ack = reg_ack; s_rdata = reg_rdata; s_err = reg_err;
    chk("core_gnt",    64'(core_gnt),    64'(eg));
    chk("core_yield",  64'(core_yield),  64'(ey));
    chk("mem_cs",      64'(mem_cs),      64'(ecs));
    if (ecs) chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("core_rvalid", 64'(core_rvalid), 64'(m_prev_gnt));
    if (m_prev_gnt) chk("core_rdata", core_rdata, mem[m_prev_caddr]);
    chk("reg_ack",     64'(reg_ack),     64'(m_ack));
    chk("reg_rdata",   reg_rdata,        m_rdata);
    chk("reg_err",     64'(reg_err),     64'(m_err));
    @(posedge clk);
    new_ack = (m_busy && m_age == 1) || (m_ack && rr);
    if (m_busy) begin
      if (m_age == 1) begin
        m_rdata = mem[m_gaddr];
        m_err   = ecc[m_gaddr];
      end
      if (m_age >= 3 && !rr) m_busy = 0;
      else m_age++;
    end else if (m_pend) begin
      if (rg) begin
        m_pend = 0; m_busy = 1; m_age = 1; m_gaddr = ra; m_runs = 0;
      end else if (!rr) begin
        m_pend = 0; m_runs = 0;
      end else if (eg) begin
        m_runs++;
      end
    end else if (m_ready && rr) begin
      m_pend = 1;
    end
    m_ack = new_ack;
    m_prev_gnt = eg;
    m_prev_caddr = ca;
    m_ready = 1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = {$urandom, $urandom};
      ecc[i] = ($urandom_range(7) == 0);
    end
    mem[10'h05A] = 64'hDEAD;                 ecc[10'h05A] = 1'b0;
    mem[10'h3FF] = 64'h0123_4567_89AB_CDEF;
    mem[10'h0F0] = 64'hBAD0_0000_0000_0BAD;  ecc[10'h0F0] = 1'b1;
    mem[10'h123] = 64'h1111_2222_3333_4444;  ecc[10'h123] = 1'b0;
    mem[10'h201] = 64'h5555_6666_7777_8888;  ecc[10'h201] = 1'b0;

    #2;
    do_reset(1'b1);
    // first edge after release stays idle even with core_req high
    step(1, 10'h010, 0, '0);
    chk("first_edge_idle", 64'(s_gnt), 64'd0);
    step(0, '0, 0, '0);

    // core single read at top address
    step(1, 10'h3FF, 0, '0);
    chk("core_gnt_3ff", 64'(s_gnt), 64'd1);
    step(0, '0, 0, '0);
    chk("core_rvalid_3ff", 64'(s_rvalid), 64'd1);

    // register read with idle core
    step(0, '0, 1, 10'h05A);
    step(0, '0, 1, 10'h05A);
    chk("reg_cs_c1", 64'(s_cs), 64'd1);
    chk("reg_addr_c1", 64'(s_addr), 64'h05A);
    step(0, '0, 1, 10'h05A);
    step(0, '0, 1, 10'h05A);
    chk("reg_ack_c3", 64'(s_ack), 64'd1);
    chk("reg_rdata_c3", s_rdata, 64'hDEAD);
    chk("reg_err_c3", 64'(s_err), 64'd0);
    step(0, '0, 0, '0);
    chk("ack_through_drop", 64'(s_ack), 64'd1);
    step(0, '0, 0, '0);
    chk("ack_cleared", 64'(s_ack), 64'd0);

    // core load: MAX_CORE_RUN grants then the register takes the slot
    for (int i = 0; i <= MAXR + 1; i++) begin
      step(1, 10'(i), 1, 10'h123);
      if (i >= 1 && i <= MAXR) chk("run_core_gnt", 64'(s_gnt), 64'd1);
      if (i == MAXR + 1) begin
        chk("run_yield", 64'(s_yield), 64'd1);
        chk("run_gnt_lost", 64'(s_gnt), 64'd0);
        chk("run_mem_addr", 64'(s_addr), 64'h123);
      end
    end
    step(1, 10'h040, 1, 10'h123);
    chk("yield_no_rvalid", 64'(s_rvalid), 64'd0);
    step(1, 10'h041, 1, 10'h123);
    chk("run_reg_ack", 64'(s_ack), 64'd1);
    step(1, 10'h042, 0, '0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0);

    // withdraw while pending under core load
    step(1, 10'h050, 1, 10'h200);
    step(1, 10'h051, 1, 10'h200);
    step(1, 10'h052, 1, 10'h200);
    for (int i = 0; i < 4; i++) begin
      step(1, 10'(10'h060 + i), 0, '0);
      chk("withdraw_no_ack", 64'(s_ack), 64'd0);
      chk("withdraw_core_addr", 64'(s_addr), 64'(10'h060 + i));
    end
    // run count restarted: yield again after exactly MAXR core grants
    for (int i = 0; i <= MAXR + 1; i++) begin
      step(1, 10'(10'h070 + i), 1, 10'h201);
      chk("rerun_yield", 64'(s_yield), 64'(i == MAXR + 1));
    end
    step(1, 10'h080, 1, 10'h201);
    step(1, 10'h081, 1, 10'h201);
    step(0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0);

    // ECC error on a register read, then a clean read clears it
    for (int i = 0; i < 4; i++) step(0, '0, 1, 10'h0F0);
    chk("ecc_ack", 64'(s_ack), 64'd1);
    chk("ecc_err", 64'(s_err), 64'd1);
    step(0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 10'h05A);
    chk("clean_err", 64'(s_err), 64'd0);
    chk("clean_rdata", s_rdata, 64'hDEAD);
    step(0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0);

    // reset during CAP discards the read; the held request then completes
    for (int i = 0; i < 3; i++) step(0, '0, 1, 10'h0F0);
    reg_req = 1'b1;
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 1, 10'h0F0);
      if (i < 4) chk("post_rst_no_ack", 64'(s_ack), 64'd0);
    end
    chk("post_rst_ack", 64'(s_ack), 64'd1);
    chk("post_rst_rdata", s_rdata, 64'hBAD0_0000_0000_0BAD);
    step(0, '0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, '0);

    // randomized traffic: heavy then light core load
    rq = 0; rq_addr = '0; low_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic cr;
      if (n < 1500) cr = ($urandom_range(9) != 0);
      else cr = ($urandom_range(9) < 4);
      if (!rq) begin
        if (low_cnt > 0) low_cnt--;
        else if ($urandom_range(3) == 0) begin
          rq = 1;
          rq_addr = 10'($urandom_range(1023));
        end
      end else if (m_ack ? ($urandom_range(1) == 0) : ($urandom_range(15) == 0)) begin
        rq = 0;
        low_cnt = 3;
      end
      step(cr, 10'($urandom_range(1023)), rq, rq_addr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cr_prefix_rec_arb.md
CR_PREFIX_REC_ARB -- requirements
Module: cr_prefix_rec_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, record-memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, record-memory read-data width.
REQ-003 SHALL have parameter MAX_CORE_RUN, default 4, legal range 1-15; this is the maximum number of consecutive core grants while a register read is pending.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port core_req, input, 1 bit: core read request, valid for one cycle.
REQ-007 SHALL have port core_addr, input, ADDR_W bits: core read address.
REQ-008 SHALL have port core_gnt, output, 1 bit: combinational grant of core_req this cycle.
REQ-009 SHALL have port core_yield, output, 1 bit: core lost the slot to a register read this cycle.
REQ-010 SHALL have port core_rvalid, output, 1 bit: core read data valid.
REQ-011 SHALL have port core_rdata, output, DATA_W bits: core read data.
REQ-012 SHALL have port reg_req, input, 1 bit: register indirect read request, 4-phase level.
REQ-013 SHALL have port reg_addr, input, ADDR_W bits: register read address, stable while reg_req=1.
REQ-014 SHALL have port reg_ack, output, 1 bit: register read complete.
REQ-015 SHALL have port reg_rdata, output, DATA_W bits: captured register read data.
REQ-016 SHALL have port reg_err, output, 1 bit: uncorrectable ECC seen on the register read.
REQ-017 SHALL have port mem_cs, output, 1 bit: record-memory chip select.
REQ-018 SHALL have port mem_addr, output, ADDR_W bits: record-memory address.
REQ-019 SHALL have port mem_rdata, input, DATA_W bits: memory data, one cycle after mem_cs.
REQ-020 SHALL have port mem_ecc_err, input, 1 bit: uncorrectable ECC flag, aligned with mem_rdata.

Function
REQ-021 SHALL implement register FSM states IDLE, PEND, RD, CAP, ACK.
REQ-022 SHALL make these FSM transitions: IDLE->PEND on reg_req=1; PEND->RD on register grant; RD->CAP unconditionally; CAP->ACK unconditionally; ACK->IDLE when reg_req=0.
REQ-023 SHALL grant the register in PEND when core_req=0 or run_ctr==MAX_CORE_RUN.
REQ-024 SHALL otherwise set core_gnt=core_req in every state.
REQ-025 SHALL maintain run_ctr (4 bits): increment in PEND when core_gnt=1, clear on PEND->RD, hold elsewhere, and never exceed MAX_CORE_RUN.
REQ-026 SHALL assert core_yield=1 exactly when core_req=1 and the register is granted that cycle; core_gnt=0 in that cycle and the core request is dropped, not queued.
REQ-027 SHALL drive mem_cs=core_gnt|(register grant), combinationally.
REQ-028 SHALL drive mem_addr=reg_addr on a register grant, else core_addr.
REQ-029 SHALL set core_rvalid as a registered copy of core_gnt, giving 1-cycle latency.
REQ-030 SHALL drive core_rdata=mem_rdata unregistered; it is qualified by core_rvalid.
REQ-031 SHALL issue the register memory read in the PEND cycle that is granted.
REQ-032 SHALL capture mem_rdata into reg_rdata and mem_ecc_err into reg_err in RD, one cycle after the grant.
REQ-033 SHALL register reg_ack=1 from the state entering ACK through the cycle reg_req is sampled 0.
REQ-034 SHALL make the register-grant-to-reg_ack latency exactly 2 cycles.
REQ-035 SHALL hold reg_rdata and reg_err until the next capture.
REQ-036 SHALL, if reg_req drops while in PEND, return the FSM to IDLE without a memory read; run_ctr clears.
REQ-037 SHALL, if reg_req drops in RD or CAP, complete the read, present reg_ack for one cycle, then go to IDLE.
REQ-038 SHALL not assert core_yield while the FSM is in IDLE, RD, CAP or ACK.
REQ-039 SHALL, with MAX_CORE_RUN=N and core_req continuously 1, grant the register no later than N+1 cycles after entry to PEND.

Reset
REQ-040 SHALL, on rst=1, asynchronously force FSM=IDLE, run_ctr=0, core_rvalid=0, reg_ack=0, reg_rdata=0 and reg_err=0.
REQ-041 SHALL hold core_gnt=0, core_yield=0 and mem_cs=0 while rst=1.
REQ-042 SHALL, if reset is asserted mid-read, discard the outstanding read with no reg_ack; the requester re-issues the read after reset.
REQ-043 SHALL, after rst deasserts, leave the first sampling edge idle and accept requests from the next edge.

Verification
REQ-044 SHALL cover: idle core, reg_req=1 with reg_addr=0x05A and mem data 0xDEAD -> mem_cs with mem_addr=0x05A in cycle 1, reg_ack in cycle 3 with reg_rdata=0xDEAD, reg_err=0.
REQ-045 SHALL cover: core_req held 1 with MAX_CORE_RUN=4, then reg_req=1 -> 4 core grants, 5th cycle core_yield=1 and mem_addr=reg_addr, core_rvalid=0 on the following cycle.
REQ-046 SHALL cover: core single read addr=0x3FF -> core_gnt=1 same cycle, core_rvalid=1 with core_rdata=mem_rdata next cycle.
REQ-047 SHALL cover: reg_req withdrawn in PEND under core load -> no register memory read, reg_ack never asserted, run_ctr=0.
REQ-048 SHALL cover: mem_ecc_err=1 on a register read -> reg_err=1 with reg_ack; the next clean read clears reg_err.
REQ-049 SHALL cover: rst pulsed in CAP -> reg_ack stays 0, FSM=IDLE, and a subsequent reg_req completes normally.
